// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Watches a data-memory write port and checks it against an ordered table of
//   expected {address, data} stores. Stores that fall in a tolerated address
//   window are skipped. The verdict (done/pass/fail_code) is registered.
//
//   Optional feature: define MWC_TIMEOUT_EN to fail with code 3 once the run
//   has been armed for TIMEOUT cycles without a verdict.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cfg_we/idx/addr/data  table write port (ignored while ARMED)
//   cfg_len               number of valid table entries, latched on start
//   ign_base, ign_mask    tolerated window: (DataAdr & mask) == (base & mask)
//   start                 arm the checker (ignored while ARMED)
//   MemWrite, DataAdr,
//   WriteData             observed store port
//   done, pass, fail_code verdict (code 0 none, 1 data, 2 address, 3 timeout)
//   match_cnt             entries matched in the current run
//   cycle_cnt             cycles spent ARMED, saturating
//
// state | meaning
// IDLE  | after reset, waiting for start
// ARMED | checking stores against the table
// PASS  | all expected stores seen in order
// FAIL  | a bad store (or timeout) ended the run
module mem_write_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W:0]    cfg_len,
    input  logic [ADDR_W-1:0] ign_base,
    input  logic [ADDR_W-1:0] ign_mask,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W:0]    match_cnt,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} stateT;

`ifdef MWC_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam logic [IDX_W:0] DEPTH_L   = (IDX_W+1)'(DEPTH);
    localparam logic [31:0]    TIMEOUT_L = 32'(TIMEOUT - 1);

    stateT state, stateNext;

    logic [ADDR_W-1:0] addrTab [DEPTH];
    logic [DATA_W-1:0] dataTab [DEPTH];
    logic [IDX_W:0]    len;
    logic [IDX_W-1:0]  ptr;

    logic [IDX_W:0] lenClamped;
    logic           hitAddr, hitData, inWindow, lastEntry, timeoutHit;
    logic           arm, ptrInc;
    logic           doneNext, passNext;
    logic [1:0]     codeNext;

    assign lenClamped = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
    assign hitAddr    = (DataAdr == addrTab[ptr]);
    assign hitData    = (WriteData == dataTab[ptr]);
    assign inWindow   = ((DataAdr & ign_mask) == (ign_base & ign_mask));
    assign lastEntry  = ({1'b0, ptr} == (len - (IDX_W+1)'(1)));
    assign timeoutHit = TIMEOUT_ON && (cycle_cnt == TIMEOUT_L);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        doneNext  = done;
        passNext  = pass;
        codeNext  = fail_code;
        arm       = 1'b0;
        ptrInc    = 1'b0;
        case (state)
            ARMED: begin
                // Exact hit beats the window, the window beats a data mismatch.
                if (MemWrite && hitAddr && hitData) begin
                    ptrInc = 1'b1;
                    if (lastEntry) begin
                        stateNext = PASS;
                        doneNext  = 1'b1;
                        passNext  = 1'b1;
                    end
                end else if (MemWrite && inWindow) begin
                    stateNext = ARMED;
                end else if (MemWrite && hitAddr) begin
                    stateNext = FAIL;
                    doneNext  = 1'b1;
                    codeNext  = 2'd1;
                end else if (MemWrite) begin
                    stateNext = FAIL;
                    doneNext  = 1'b1;
                    codeNext  = 2'd2;
                end
                // A store that decides the run wins over the timeout.
                if (timeoutHit && stateNext == ARMED) begin
                    stateNext = FAIL;
                    doneNext  = 1'b1;
                    codeNext  = 2'd3;
                end
            end
            default: begin
                if (start) begin
                    arm      = 1'b1;
                    codeNext = 2'd0;
                    if (lenClamped == '0) begin
                        stateNext = PASS;
                        doneNext  = 1'b1;
                        passNext  = 1'b1;
                    end else begin
                        stateNext = ARMED;
                        doneNext  = 1'b0;
                        passNext  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= 2'd0;
            match_cnt <= '0;
            cycle_cnt <= '0;
            len       <= '0;
            ptr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addrTab[i] <= '0;
                dataTab[i] <= '0;
            end
        end else begin
            done      <= doneNext;
            pass      <= passNext;
            fail_code <= codeNext;
            // Writes in the arming cycle land before the first checked store.
            if (cfg_we && state != ARMED) begin
                addrTab[cfg_idx] <= cfg_addr;
                dataTab[cfg_idx] <= cfg_data;
            end
            if (arm) begin
                len       <= lenClamped;
                ptr       <= '0;
                match_cnt <= '0;
                cycle_cnt <= '0;
            end else if (state == ARMED) begin
                if (ptrInc) begin
                    ptr       <= ptr + (IDX_W)'(1);
                    match_cnt <= match_cnt + (IDX_W+1)'(1);
                end
                // Frozen on the edge that leaves ARMED.
                if (stateNext == ARMED && cycle_cnt != '1)
                    cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [2:0]    cfg_len = '0;
    logic [AW-1:0] ign_base = '0;
    logic [AW-1:0] ign_mask = '0;
    logic          start = 1'b0;
    logic          MemWrite = 1'b0;
    logic [AW-1:0] DataAdr = '0;
    logic [DW-1:0] WriteData = '0;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;
    logic [2:0]    match_cnt;
    logic [31:0]   cycle_cnt;

    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
        .ign_base(ign_base), .ign_mask(ign_mask), .start(start),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done), .pass(pass), .fail_code(fail_code),
        .match_cnt(match_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;

    typedef struct {
        string       name;
        logic        expPass;
        logic [1:0]  expCode;
        logic [2:0]  expMatch;
        logic [31:0] expCycles;
    } verdictT;
    verdictT sbq[$];

    typedef struct {
        logic [31:0] mask;
        logic        hasPre;
        logic [31:0] preA, preD, a, d;
        logic        expPass;
        logic [1:0]  expCode;
        logic [2:0]  expMatch;
    } vecT;
    vecT vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cfgWrite(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic arm(input logic [2:0] len);
        cfg_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic pushExp(input string n, input logic p, input logic [1:0] c,
                           input logic [2:0] m, input logic [31:0] cyc);
        verdictT v;
        v.name = n; v.expPass = p; v.expCode = c; v.expMatch = m; v.expCycles = cyc;
        sbq.push_back(v);
    endtask

    // Waits (bounded) for done, then pops the oldest expected verdict and compares.
    task automatic collect(input int maxWait, input int expLat);
        verdictT v;
        int waited;
        waited = 0;
        while (done !== 1'b1 && waited < maxWait) begin
            @(negedge clk);
            waited++;
        end
        if (sbq.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL collect: scoreboard empty with done=%b", done);
        end else begin
            v = sbq.pop_front();
            if (done !== 1'b1) begin
                nCmp++; nBad++;
                $display("FAIL %s done: got %b after %0d cycles, required 1", v.name, done, maxWait);
            end else begin
                chk({v.name, " latency"}, waited, expLat);
                chk({v.name, " pass"}, pass, v.expPass);
                chk({v.name, " fail_code"}, fail_code, v.expCode);
                chk({v.name, " match_cnt"}, match_cnt, v.expMatch);
                chk({v.name, " cycle_cnt"}, cycle_cnt, v.expCycles);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        // len=1, entry {100,7}, ign_base=96
        vecs[0] = '{32'hFFFF_FFFF, 1'b1, 96, 3, 100, 7, 1'b1, 2'd0, 3'd1};
        vecs[1] = '{32'hFFFF_FFFF, 1'b0, 0, 0, 100, 8, 1'b0, 2'd1, 3'd0};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 0, 0, 104, 7, 1'b0, 2'd2, 3'd0};
        vecs[3] = '{32'hFFFF_FFF0, 1'b1, 104, 9, 100, 7, 1'b1, 2'd0, 3'd1};
        vecs[4] = '{32'hFFFF_FFF0, 1'b1, 100, 9, 100, 7, 1'b1, 2'd0, 3'd1};
        vecs[5] = '{32'hFFFF_FFF0, 1'b0, 0, 0, 32'h70, 7, 1'b0, 2'd2, 3'd0};
        vecs[6] = '{32'hFFFF_FFFF, 1'b1, 96, 7, 100, 0, 1'b0, 2'd1, 3'd0};

        doReset();
        chk("reset done", done, 0);
        chk("reset pass", pass, 0);
        chk("reset fail_code", fail_code, 0);
        chk("reset match_cnt", match_cnt, 0);
        chk("reset cycle_cnt", cycle_cnt, 0);

        for (int i = 0; i < 7; i++) begin
            ign_base = 32'd96;
            ign_mask = vecs[i].mask;
            cfgWrite(2'd0, 32'd100, 32'd7);
            arm(3'd1);
            chk($sformatf("vec%0d armed done", i), done, 0);
            if (vecs[i].hasPre) begin
                store(vecs[i].preA, vecs[i].preD);
                chk($sformatf("vec%0d window store done", i), done, 0);
            end
            pushExp($sformatf("vec%0d", i), vecs[i].expPass, vecs[i].expCode,
                    vecs[i].expMatch, vecs[i].hasPre ? 32'd1 : 32'd0);
            store(vecs[i].a, vecs[i].d);
            collect(10, 0);
        end

        // Out-of-order store to a later entry, then in-order replay.
        ign_base = 32'hFFFF_0000;
        ign_mask = 32'hFFFF_FFFF;
        cfgWrite(2'd0, 32'h10, 32'd1);
        cfgWrite(2'd1, 32'h14, 32'd2);
        cfgWrite(2'd2, 32'h18, 32'd3);
        arm(3'd3);
        store(32'h10, 32'd1);
        pushExp("out-of-order", 1'b0, 2'd2, 3'd1, 32'd1);
        store(32'h18, 32'd3);
        collect(10, 0);

        arm(3'd3);
        chk("rearm done", done, 0);
        chk("rearm fail_code", fail_code, 0);
        chk("rearm match_cnt", match_cnt, 0);
        chk("rearm cycle_cnt", cycle_cnt, 0);
        store(32'h10, 32'd1);
        store(32'h14, 32'd2);
        pushExp("in-order", 1'b1, 2'd0, 3'd3, 32'd2);
        store(32'h18, 32'd3);
        collect(10, 0);
        store(32'h99, 32'h99);
        chk("store after pass: pass", pass, 1);
        chk("store after pass: match_cnt", match_cnt, 3);

        // start and cfg_we while ARMED are both ignored.
        arm(3'd3);
        store(32'h10, 32'd1);
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd1; cfg_addr = 32'h40; cfg_data = 32'h40;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        chk("start while armed: match_cnt", match_cnt, 1);
        chk("start while armed: done", done, 0);
        store(32'h14, 32'd2);
        pushExp("armed cfg ignored", 1'b1, 2'd0, 3'd3, 32'd3);
        store(32'h18, 32'd3);
        collect(10, 0);

        // cfg_we + start same cycle, cfg_len clamp, store with start not checked.
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_addr = 32'h1C; cfg_data = 32'd4;
        cfg_len = 3'd7; start = 1'b1;
        MemWrite = 1'b1; DataAdr = 32'h55; WriteData = 32'h55;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0; MemWrite = 1'b0;
        chk("store with start: done", done, 0);
        chk("store with start: fail_code", fail_code, 0);
        store(32'h10, 32'd1);
        store(32'h14, 32'd2);
        store(32'h18, 32'd3);
        pushExp("clamped len", 1'b1, 2'd0, 3'd4, 32'd3);
        store(32'h1C, 32'd4);
        collect(10, 0);

        // Timeout behaviour.
        cfgWrite(2'd0, 32'h10, 32'd1);
        arm(3'd1);
`ifdef MWC_TIMEOUT_EN
        pushExp("timeout", 1'b0, 2'd3, 3'd0, 32'd49);
        collect(100, 50);
`else
        repeat (200) @(negedge clk);
        chk("no timeout: done", done, 0);
        chk("no timeout: fail_code", fail_code, 0);
        chk("no timeout: cycle_cnt", cycle_cnt, 200);
`endif

        // Reset mid-check, then len=0 start, then table cleared by reset.
        doReset();
        cfgWrite(2'd0, 32'h10, 32'd1);
        cfgWrite(2'd1, 32'h14, 32'd2);
        arm(3'd2);
        store(32'h10, 32'd1);
        chk("pre-reset match_cnt", match_cnt, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset done", done, 0);
        chk("mid reset pass", pass, 0);
        chk("mid reset fail_code", fail_code, 0);
        chk("mid reset match_cnt", match_cnt, 0);
        chk("mid reset cycle_cnt", cycle_cnt, 0);
        pushExp("len0", 1'b1, 2'd0, 3'd0, 32'd0);
        arm(3'd0);
        collect(10, 0);
        arm(3'd1);
        pushExp("cleared table", 1'b1, 2'd0, 3'd1, 32'd0);
        store(32'h0, 32'h0);
        collect(10, 0);

        chk("scoreboard drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nBad);
        $finish;
    end

endmodule
